prescaled_counter: RTL

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

---
 rtl/prescaled_counter.sv | 82 ++++++++
 1 files changed

// File: rtl/prescaled_counter.sv
// Up/down counter advanced by an enable-gated prescaler tick; sync clear/load, wrap flag.
// Latency: count and wrap update one clk edge after the tick/clr/load; tick and tc are combinational.
// Backpressure: none; en freezes prescaler and counter, clr and load always take effect.
// Optional macro COUNTER_SATURATE_EN: a tick at the terminal value holds count and wrap stays 0.
module prescaled_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRE_W   = 26,
  parameter int unsigned DIV_MAX = 32112212
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             wrap
);

  localparam logic [PRE_W-1:0] DIV_LIM = PRE_W'(DIV_MAX);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  // Tick fires on the last enabled cycle of each prescaler period; tc looks at the direction boundary.
  always_comb begin
    tick = en && (pre_q == DIV_LIM);
    tc   = up_dn ? (&cnt_q) : ~(|cnt_q);
  end

  // Prescaler: clear wins, otherwise counts enabled cycles and reloads after the terminal value.
  // A load leaves the prescaler running untouched.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Counter: clear, then load, then tick-driven count; wrap only from a tick crossing a boundary.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick) begin
`ifdef COUNTER_SATURATE_EN
      if (!tc) begin
        cnt_d = up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
`else
      cnt_d  = up_dn ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      wrap_d = tc;
`endif
    end
  end

  // State registers with immediate clear on reset assertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign count = cnt_q;
  assign wrap  = wrap_q;

endmodule
